// File: rtl/hamming_serial_encoder.sv
// Hamming(21,16) encoder feeding a flow-controlled serial link.
// One-entry hold register lets the next word queue while the current frame shifts out.
module hamming_serial_encoder #(
   parameter bit          LSB_FIRST = 1'b1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_data,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_sof,
   output logic             ser_eof,
   output logic [20:0]      cw_last,
   output logic [CNT_W-1:0] frames_sent
);

   localparam int unsigned CW_W     = 21;
   localparam int unsigned IDX_W    = 5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CW_W - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state, state_n;
   logic [CW_W-1:0]   sh, sh_n;
   logic [CW_W-1:0]   hr, hr_n;
   logic              hv, hv_n;
   logic [IDX_W-1:0]  idx, idx_n;
   logic [CW_W-1:0]   cw_q, cw_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [CW_W-1:0]   enc_c;
   logic [IDX_W-1:0]  bit_sel_c;
   logic              accept_c;
   logic              frame_end_c;
   logic              direct_c;

   // Check bits sit at positions 0,1,3,7,15 so the decoder syndrome is zero when clean.
   function automatic logic [CW_W-1:0] encode(input logic [15:0] d);
      logic [CW_W-1:0] c;
      c        = '0;
      c[2]     = d[0];
      c[4]     = d[1];
      c[5]     = d[2];
      c[6]     = d[3];
      c[14:8]  = d[10:4];
      c[20:16] = d[15:11];
      c[0]     = ^{c[2], c[4], c[6], c[8], c[10], c[12], c[14], c[16], c[18], c[20]};
      c[1]     = ^{c[2], c[5], c[6], c[9], c[10], c[13], c[14], c[17], c[18]};
      c[3]     = ^{c[4], c[5], c[6], c[11], c[12], c[13], c[14], c[19], c[20]};
      c[7]     = ^c[14:8];
      c[15]    = ^c[20:16];
      return c;
   endfunction

   assign enc_c       = encode(in_data);
   assign accept_c    = in_valid && !hv;
   assign frame_end_c = (state == SHIFT) && ser_ready && (idx == LAST_IDX);
   // A word arriving on the last bit with an empty hold register goes straight to the shifter.
   assign direct_c    = frame_end_c && !hv && accept_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sh    <= '0;
         hr    <= '0;
         hv    <= 1'b0;
         idx   <= '0;
         cw_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         hr    <= hr_n;
         hv    <= hv_n;
         idx   <= idx_n;
         cw_q  <= cw_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      sh_n    = sh;
      hr_n    = hr;
      hv_n    = hv;
      idx_n   = idx;
      cw_n    = cw_q;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept_c) begin
               sh_n    = enc_c;
               cw_n    = enc_c;
               idx_n   = '0;
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (ser_ready) begin
               if (idx != LAST_IDX) begin
                  idx_n = idx + IDX_W'(1);
               end else begin
                  cnt_n = cnt + CNT_W'(1);
                  idx_n = '0;
                  if (hv) begin
                     sh_n = hr;
                     cw_n = hr;
                     hv_n = 1'b0;
                  end else if (accept_c) begin
                     sh_n = enc_c;
                     cw_n = enc_c;
                  end else begin
                     state_n = IDLE;
                  end
               end
            end
            if (accept_c && !direct_c) begin
               hr_n = enc_c;
               hv_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // Serial outputs decode registered state only; no path from ser_ready.
   assign bit_sel_c   = LSB_FIRST ? idx : (LAST_IDX - idx);
   assign ser_valid   = (state == SHIFT);
   assign ser_data    = ser_valid && sh[bit_sel_c];
   assign ser_sof     = ser_valid && (idx == '0);
   assign ser_eof     = ser_valid && (idx == LAST_IDX);
   assign in_ready    = !hv;
   assign cw_last     = cw_q;
   assign frames_sent = cnt;

endmodule

// File: tb/tb_hamming_serial_encoder.sv
// Bench for hamming_serial_encoder: table vectors, streaming, backpressure, reset, MSB-first/narrow counter.
`timescale 1ns/1ps
module tb_hamming_serial_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic        ser_data, ser_valid, ser_sof, ser_eof;
   logic        ser_ready = 1'b1;
   logic [20:0] cw_last;
   logic [15:0] frames_sent;

   logic [15:0] in_data2;
   logic        in_valid2, in_ready2;
   logic        ser_data2, ser_valid2, ser_sof2, ser_eof2;
   logic        ser_ready2;
   logic [20:0] cw_last2;
   logic [1:0]  frames_sent2;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit bp_en = 1'b0;

   always #5 clk = ~clk;

   hamming_serial_encoder #(.LSB_FIRST(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .ser_sof(ser_sof), .ser_eof(ser_eof), .cw_last(cw_last), .frames_sent(frames_sent));

   hamming_serial_encoder #(.LSB_FIRST(1'b0), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .ser_data(ser_data2), .ser_valid(ser_valid2), .ser_ready(ser_ready2),
      .ser_sof(ser_sof2), .ser_eof(ser_eof2), .cw_last(cw_last2), .frames_sent(frames_sent2));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Reference: generic Hamming placement, checks at 1-based power-of-two positions.
   function automatic logic [20:0] enc_model(input logic [15:0] d);
      logic [20:0] c;
      int j;
      c = '0;
      j = 0;
      for (int p = 0; p < 21; p++) begin
         if ((((p + 1) & p)) != 0) begin
            c[p] = d[j];
            j++;
         end
      end
      for (int k = 0; k < 5; k++) begin
         logic par;
         par = 1'b0;
         for (int p = 0; p < 21; p++)
            if (((((p + 1) >> k) & 1) == 1) && (p != ((1 << k) - 1))) par ^= c[p];
         c[(1 << k) - 1] = par;
      end
      return c;
   endfunction

   // ser_ready driver: constant 1 unless random backpressure is enabled.
   always @(posedge clk) begin
      #1;
      ser_ready = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Monitor / scoreboard sampled on the falling edge.
   logic [20:0] q[$];
   logic [20:0] rx;
   logic [20:0] exp_cw;
   logic [3:0]  prev_out;
   bit          prev_stall = 1'b0;
   int          bitcnt = 0;
   int          run = 0;
   int          max_run = 0;
   logic [15:0] exp_frames = '0;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         bitcnt     = 0;
         exp_frames = '0;
         prev_stall = 1'b0;
         run        = 0;
      end else begin
         if (prev_stall)
            check("stall_hold", 32'({ser_valid, ser_data, ser_sof, ser_eof}), 32'(prev_out));
         prev_stall = ser_valid && !ser_ready;
         prev_out   = {ser_valid, ser_data, ser_sof, ser_eof};
         run = ser_valid ? run + 1 : 0;
         if (run > max_run) max_run = run;
         if (in_valid && in_ready) q.push_back(enc_model(in_data));
         if (ser_valid && ser_ready) begin
            check("sof_eof", 32'({ser_sof, ser_eof}), 32'({bitcnt == 0, bitcnt == 20}));
            rx[bitcnt] = ser_data;
            if (bitcnt == 20) begin
               if (q.size() == 0) begin
                  check("frame_unexpected", 32'(0), 32'(1));
               end else begin
                  exp_cw = q.pop_front();
                  check("frame_bits", 32'(rx), 32'(exp_cw));
                  check("cw_last_frame", 32'(cw_last), 32'(exp_cw));
               end
               exp_frames++;
               bitcnt = 0;
            end else begin
               bitcnt++;
            end
         end
      end
   end

   task automatic send(input logic [15:0] d, input bit keep);
      bit rdy, ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      for (int i = 0; i < 500; i++) begin
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) begin ok = 1'b1; break; end
      end
      if (!keep) in_valid = 1'b0;
      if (!ok) check("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic send2(input logic [15:0] d);
      bit rdy, ok;
      ok = 1'b0;
      in_valid2 = 1'b1;
      in_data2  = d;
      for (int i = 0; i < 500; i++) begin
         rdy = in_ready2;
         @(posedge clk); #1;
         if (rdy) begin ok = 1'b1; break; end
      end
      in_valid2 = 1'b0;
      if (!ok) check("send2_timeout", 32'(0), 32'(1));
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         @(posedge clk); #1;
         if (!ser_valid && q.size() == 0) begin ok = 1'b1; break; end
      end
      if (!ok) check("idle_timeout", 32'(0), 32'(1));
   endtask

   typedef struct {
      logic [15:0] data;
      logic [20:0] cw;
   } vec_t;

   vec_t        vecs[5];
   logic [15:0] base;
   logic [20:0] rx2;
   logic [1:0]  exp_f2;

   initial begin
      vecs[0] = '{16'h0001, 21'h000007};
      vecs[1] = '{16'hFFFF, 21'h1FFFFE};
      vecs[2] = '{16'h0000, 21'h000000};
      vecs[3] = '{16'h0002, 21'h000019};
      vecs[4] = '{16'h8000, 21'h108009};

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      in_valid2 = 1'b0; in_data2 = '0; ser_ready2 = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ser_valid", 32'(ser_valid), 32'(0));
      check("rst_ser_data", 32'(ser_data), 32'(0));
      check("rst_sof_eof", 32'({ser_sof, ser_eof}), 32'(0));
      check("rst_in_ready", 32'(in_ready), 32'(1));
      check("rst_frames", 32'(frames_sent), 32'(0));
      check("rst_cw_last", 32'(cw_last), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;

      // Table vectors, one isolated frame each.
      foreach (vecs[i]) begin
         send(vecs[i].data, 1'b0);
         check("latency_first_bit", 32'({ser_valid, ser_sof}), 32'(2'b11));
         check("tbl_cw_last", 32'(cw_last), 32'(vecs[i].cw));
         wait_idle();
         check("tbl_frames", 32'(frames_sent), 32'(i + 1));
      end

      // Back-to-back streaming: three frames with no gap.
      max_run = 0;
      base = exp_frames;
      send(16'hA5A5, 1'b1);
      send(16'h5A5A, 1'b1);
      check("b2b_in_ready_low", 32'(in_ready), 32'(0));
      send(16'h1234, 1'b0);
      wait_idle();
      check("b2b_run", 32'(max_run), 32'(63));
      check("b2b_frames", 32'(frames_sent), 32'(base + 16'd3));

      // Random backpressure over 1000 random words.
      base = exp_frames;
      bp_en = 1'b1;
      for (int i = 0; i < 1000; i++) send(16'($urandom), (i != 999));
      wait_idle();
      bp_en = 1'b0;
      @(posedge clk); #1;
      check("bp_frames", 32'(frames_sent), 32'(base + 16'd1000));
      check("bp_frames_model", 32'(frames_sent), 32'(exp_frames));

      // Reset at idx 10 drops the partial frame.
      send(16'hFFFF, 1'b0);
      repeat (10) begin @(posedge clk); #1; end
      check("mid_valid_before_rst", 32'(ser_valid), 32'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_valid", 32'(ser_valid), 32'(0));
      check("mid_rst_in_ready", 32'(in_ready), 32'(1));
      check("mid_rst_frames", 32'(frames_sent), 32'(0));
      check("mid_rst_sof_eof", 32'({ser_sof, ser_eof, ser_data}), 32'(0));
      rst = 1'b0;
      @(posedge clk); #1;
      send(16'h0001, 1'b0);
      wait_idle();
      check("post_rst_frames", 32'(frames_sent), 32'(1));
      check("post_rst_cw", 32'(cw_last), 32'(21'h000007));

      // MSB-first instance: capture stream order, 2-bit counter wraps.
      send2(16'h0001);
      rx2 = '0;
      for (int k = 0; k < 21; k++) begin
         if (k == 0) check("msb_sof", 32'({ser_valid2, ser_sof2, ser_eof2}), 32'(3'b110));
         if (k == 20) check("msb_eof", 32'({ser_valid2, ser_sof2, ser_eof2, ser_data2}), 32'(4'b1011));
         rx2[k] = ser_data2;
         @(posedge clk); #1;
      end
      check("msb_stream", 32'(rx2), 32'(21'h1C0000));
      check("msb_cw_last", 32'(cw_last2), 32'(enc_model(16'h0001)));
      check("msb_idle", 32'(ser_valid2), 32'(0));
      exp_f2 = 2'd1;
      for (int i = 0; i < 4; i++) begin
         send2(16'($urandom));
         exp_f2 = exp_f2 + 2'd1;
         for (int w = 0; w < 30 && ser_valid2; w++) begin @(posedge clk); #1; end
      end
      check("msb_idle_end", 32'(ser_valid2), 32'(0));
      check("cnt_wrap", 32'(frames_sent2), 32'(exp_f2));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
